// File: rtl/msx_bus_pkg.sv
// Shared types and defaults for the MSX slot bus initiator: command encodings,
// bus-cycle FSM states and the standard wait-state counts.
package msx_bus_pkg;

  typedef enum logic [1:0] {
    CMD_MEM_RD = 2'b00,
    CMD_MEM_WR = 2'b01,
    CMD_IO_RD  = 2'b10,
    CMD_IO_WR  = 2'b11
  } cmd_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T1,
    ST_T2,
    ST_TW,
    ST_T3,
    ST_DONE
  } state_e;

  localparam int DEF_MEM_WAIT = 0;
  localparam int DEF_M1_WAIT  = 1;
  localparam int DEF_IO_WAIT  = 1;
  localparam int DEF_TIMEOUT  = 255;

  function automatic logic is_mem(input cmd_type_e t);
    return !t[1];
  endfunction

  function automatic logic is_wr(input cmd_type_e t);
    return t[0];
  endfunction

endpackage

// File: rtl/msx_bus_master_if.sv
// Cartridge slot bus signals between the FPGA initiator and the slot responders.
interface msx_bus_master_if;
  logic [15:0] addr;
  logic [7:0]  cdout;
  logic        cdout_oe;
  logic [7:0]  cdin;
  logic        wait_n;
  logic        merq_n;
  logic        iorq_n;
  logic        sltsl_n;
  logic        rd_n;
  logic        wr_n;
  logic        m1_n;

  modport master (
    output addr, cdout, cdout_oe, merq_n, iorq_n, sltsl_n, rd_n, wr_n, m1_n,
    input  cdin, wait_n
  );

  modport slave (
    input  addr, cdout, cdout_oe, merq_n, iorq_n, sltsl_n, rd_n, wr_n, m1_n,
    output cdin, wait_n
  );
endinterface

// File: rtl/msx_wait_counter.sv
// Wait-state down-counter plus optional TW-tick watchdog for the bus initiator.
// The watchdog exists only when MSX_BUS_TIMEOUT_EN is defined.
module msx_wait_counter
  import msx_bus_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       step,
  input  logic       tw_step,
  output logic       zero,
  output logic       timeout
);

  localparam logic [7:0] TW_LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (step && cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign zero = (cnt == 8'd0);

`ifdef MSX_BUS_TIMEOUT_EN
  logic [7:0] tw_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tw_cnt <= '0;
    end else if (load) begin
      tw_cnt <= '0;
    end else if (tw_step) begin
      tw_cnt <= tw_cnt + 8'd1;
    end
  end

  // Fires on the TIMEOUT-th TW tick of the current cycle.
  assign timeout = tw_step && (tw_cnt == TW_LAST);
`else
  logic unused_cfg;
  assign unused_cfg = ^{TW_LAST, tw_step};
  assign timeout    = 1'b0;
`endif

endmodule

// File: rtl/msx_bus_master.sv
// MSX cartridge slot bus initiator: turns one valid/ready command into a
// Z80-timed mem/IO/M1 cycle. Optional watchdog: MSX_BUS_TIMEOUT_EN.
module msx_bus_master
  import msx_bus_pkg::*;
#(
  parameter int MEM_WAIT = DEF_MEM_WAIT,
  parameter int M1_WAIT  = DEF_M1_WAIT,
  parameter int IO_WAIT  = DEF_IO_WAIT,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic        cmd_m1,
  input  logic        cmd_slot,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  msx_bus_master_if.master bus
);

  localparam logic [7:0] MEM_W = 8'(MEM_WAIT);
  localparam logic [7:0] M1_W  = 8'(M1_WAIT);
  localparam logic [7:0] IO_W  = 8'(IO_WAIT);

  state_e     state_q, state_d;
  cmd_type_e  type_q;
  logic       m1_q, slot_q, err_q;
  logic [15:0] addr_q;
  logic [7:0] wdata_q, rdata_q, wait_val;
  logic       handshake, load, step, tw_step, zero, timeout, capture, force_err;
  logic       active, late, mem, wr;
  logic       merq_n, iorq_n, sltsl_n, rd_n, wr_n, m1_n, cdout_oe;

  assign handshake = (state_q == ST_IDLE) && cmd_valid;
  assign wait_val  = m1_q ? M1_W : (is_mem(type_q) ? MEM_W : IO_W);

  msx_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (wait_val),
    .step     (step),
    .tw_step  (tw_step),
    .zero     (zero),
    .timeout  (timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      type_q  <= CMD_MEM_RD;
      m1_q    <= 1'b0;
      slot_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (handshake) begin
        type_q  <= cmd_type_e'(cmd_type);
        m1_q    <= cmd_m1 && (cmd_type == CMD_MEM_RD);
        slot_q  <= cmd_slot;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        err_q   <= 1'b0;
      end
      if (force_err) err_q <= 1'b1;
      if (capture) begin
        if (err_q)               rdata_q <= 8'hFF;
        else if (is_wr(type_q))  rdata_q <= 8'h00;
        else                     rdata_q <= bus.cdin;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step      = 1'b0;
    tw_step   = 1'b0;
    capture   = 1'b0;
    force_err = 1'b0;
    case (state_q)
      ST_IDLE: if (cmd_valid) state_d = ST_T1;
      ST_T1: if (tick) begin
        state_d = ST_T2;
        load    = 1'b1;
      end
      ST_T2: if (tick) begin
        step    = 1'b1;
        state_d = (!zero || !bus.wait_n) ? ST_TW : ST_T3;
      end
      ST_TW: if (tick) begin
        step    = 1'b1;
        tw_step = 1'b1;
        if (zero && bus.wait_n) begin
          state_d = ST_T3;
        end else if (timeout) begin
          state_d   = ST_T3;
          force_err = 1'b1;
        end
      end
      ST_T3: if (tick) begin
        state_d = ST_DONE;
        capture = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Strobes decode from state only, so async reset releases them at once.
    active   = (state_q == ST_T1) || (state_q == ST_T2) || (state_q == ST_TW) || (state_q == ST_T3);
    late     = (state_q == ST_T2) || (state_q == ST_TW) || (state_q == ST_T3);
    mem      = is_mem(type_q);
    wr       = is_wr(type_q);
    merq_n   = !(active && mem);
    iorq_n   = !(late && !mem);
    rd_n     = !(!wr && (mem ? active : late));
    wr_n     = !(late && wr);
    sltsl_n  = !(active && mem && slot_q);
    m1_n     = !(active && m1_q);
    cdout_oe = wr && (mem ? active : late);
  end

  assign bus.addr     = addr_q;
  assign bus.cdout    = wdata_q;
  assign bus.cdout_oe = cdout_oe;
  assign bus.merq_n   = merq_n;
  assign bus.iorq_n   = iorq_n;
  assign bus.sltsl_n  = sltsl_n;
  assign bus.rd_n     = rd_n;
  assign bus.wr_n     = wr_n;
  assign bus.m1_n     = m1_n;

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_rdata = rdata_q;

`ifdef MSX_BUS_TIMEOUT_EN
  logic rsp_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     rsp_err_q <= 1'b0;
    else if (capture) rsp_err_q <= err_q;
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_msx_bus_master.sv
// Directed bench for msx_bus_master: table of bus cycles with hand-computed
// strobe-period counts, plus reset-during-TW and watchdog sequences.
module tb_msx_bus_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = 2'b00;
  logic        cmd_m1 = 1'b0;
  logic        cmd_slot = 1'b0;
  logic [15:0] cmd_addr = 16'h0000;
  logic [7:0]  cmd_wdata = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  msx_bus_master_if bus ();

  msx_bus_master dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_m1    (cmd_m1),
    .cmd_slot  (cmd_slot),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  typ;
    logic        m1;
    logic        slot;
    logic [15:0] a;
    logic [7:0]  wd;
    logic [7:0]  din;
    int          ws;
    int          wl;
    int          ticks;
    int          merq;
    int          iorq;
    int          rd;
    int          wr;
    int          sl;
    int          m1c;
    int          oe;
    logic [7:0]  rdata;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
    end
  endtask

  task automatic pulse_tick;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  function automatic logic [6:0] strobes();
    return {bus.merq_n, bus.iorq_n, bus.rd_n, bus.wr_n, bus.sltsl_n, bus.m1_n, bus.cdout_oe};
  endfunction

  task automatic run_vec(input vec_t v, input string tg);
    int n = 0;
    int c_merq = 0, c_iorq = 0, c_rd = 0, c_wr = 0, c_sl = 0, c_m1 = 0, c_oe = 0;
    int c_addr = 0, c_dout = 0, c_ovl = 0;
    @(negedge clk);
    bus.cdin   = v.din;
    bus.wait_n = 1'b1;
    cmd_type   = v.typ;
    cmd_m1     = v.m1;
    cmd_slot   = v.slot;
    cmd_addr   = v.a;
    cmd_wdata  = v.wd;
    cmd_valid  = 1'b1;
    chk({tg, "_ready"}, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = 16'hDEAD;
    cmd_wdata = 8'h99;
    cmd_type  = ~v.typ;
    cmd_slot  = ~v.slot;
    cmd_m1    = 1'b1;
    while (!rsp_valid && n < 600) begin
      if (!bus.merq_n)  c_merq++;
      if (!bus.iorq_n)  c_iorq++;
      if (!bus.rd_n)    c_rd++;
      if (!bus.wr_n)    c_wr++;
      if (!bus.sltsl_n) c_sl++;
      if (!bus.m1_n)    c_m1++;
      if (bus.cdout_oe) c_oe++;
      if (bus.addr !== v.a) c_addr++;
      if (bus.cdout_oe && bus.cdout !== v.wd) c_dout++;
      if ((!bus.merq_n && !bus.iorq_n) || (!bus.rd_n && !bus.wr_n)) c_ovl++;
      bus.wait_n = !(n >= v.ws && n < v.ws + v.wl);
      pulse_tick();
      n++;
    end
    chk({tg, "_ticks"}, n, v.ticks);
    chk({tg, "_rdata"}, 32'(rsp_rdata), 32'(v.rdata));
    chk({tg, "_err"}, 32'(rsp_err), 32'(v.err));
    chk({tg, "_released"}, 32'(strobes()), 32'(7'b1111110));
    chk({tg, "_busy_ready"}, 32'(cmd_ready), 32'd0);
    chk({tg, "_merq"}, c_merq, v.merq);
    chk({tg, "_iorq"}, c_iorq, v.iorq);
    chk({tg, "_rd"}, c_rd, v.rd);
    chk({tg, "_wr"}, c_wr, v.wr);
    chk({tg, "_sltsl"}, c_sl, v.sl);
    chk({tg, "_m1"}, c_m1, v.m1c);
    chk({tg, "_oe"}, c_oe, v.oe);
    chk({tg, "_addr_bad"}, c_addr, 0);
    chk({tg, "_cdout_bad"}, c_dout, 0);
    chk({tg, "_overlap"}, c_ovl, 0);
    bus.wait_n = 1'b1;
    @(negedge clk);
    chk({tg, "_valid_pulse"}, 32'(rsp_valid), 32'd0);
    chk({tg, "_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vld_seen;
    //          typ   m1    slot  addr     wdata  cdin   ws wl tk mrq ior rd wr sl m1 oe rdata  err
    vecs[0] = '{2'b00, 1'b0, 1'b1, 16'h4000, 8'h00, 8'hA5, 0, 0, 3, 3, 0, 3, 0, 3, 0, 0, 8'hA5, 1'b0};
    vecs[1] = '{2'b00, 1'b1, 1'b0, 16'h8000, 8'h00, 8'h3E, 0, 0, 4, 4, 0, 4, 0, 0, 4, 0, 8'h3E, 1'b0};
    vecs[2] = '{2'b11, 1'b0, 1'b0, 16'h008E, 8'h00, 8'hEE, 0, 0, 4, 0, 3, 0, 3, 0, 0, 3, 8'h00, 1'b0};
    vecs[3] = '{2'b01, 1'b0, 1'b1, 16'h9000, 8'h3F, 8'h77, 1, 5, 8, 8, 0, 0, 7, 8, 0, 8, 8'h00, 1'b0};
    vecs[4] = '{2'b10, 1'b0, 1'b0, 16'h00A0, 8'h00, 8'h5C, 0, 0, 4, 0, 3, 3, 0, 0, 0, 0, 8'h5C, 1'b0};
    vecs[5] = '{2'b00, 1'b0, 1'b0, 16'hFFFF, 8'h00, 8'h00, 1, 2, 5, 5, 0, 5, 0, 0, 0, 0, 8'h00, 1'b0};
    vecs[6] = '{2'b01, 1'b1, 1'b0, 16'h0000, 8'hC3, 8'h11, 0, 0, 3, 3, 0, 0, 2, 0, 0, 3, 8'h00, 1'b0};
    vecs[7] = '{2'b10, 1'b1, 1'b1, 16'h00FE, 8'h00, 8'h81, 2, 2, 6, 0, 5, 5, 0, 0, 0, 0, 8'h81, 1'b0};

    bus.cdin   = 8'h00;
    bus.wait_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_strobes", 32'(strobes()), 32'(7'b1111110));
    chk("rst_addr", 32'(bus.addr), 32'h0);
    chk("rst_cdout", 32'(bus.cdout), 32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'h0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset while an IO read sits in TW.
    @(negedge clk);
    bus.cdin   = 8'h42;
    bus.wait_n = 1'b0;
    cmd_type   = 2'b10;
    cmd_addr   = 16'h00C0;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) pulse_tick();
    chk("rsttw_pre_iorq", 32'(bus.iorq_n), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("rsttw_strobes", 32'(strobes()), 32'(7'b1111110));
    chk("rsttw_addr", 32'(bus.addr), 32'h0);
    @(negedge clk);
    reset_n    = 1'b1;
    bus.wait_n = 1'b1;
    vld_seen   = 0;
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid) vld_seen++;
      pulse_tick();
    end
    chk("rsttw_ready", 32'(cmd_ready), 32'd1);
    chk("rsttw_no_valid", vld_seen, 0);

`ifdef MSX_BUS_TIMEOUT_EN
    begin
      vec_t tv;
      tv = '{2'b00, 1'b0, 1'b1, 16'h1234, 8'h00, 8'h5A, 1, 1000, 258, 258, 0, 258, 0, 258, 0, 0, 8'hFF, 1'b1};
      run_vec(tv, "tmo");
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msx_bus_master.md
Name: msx_bus_master

Overview:
- Initiator for the MSX cartridge slot bus; the other end of the bus that mapper/SCC responders decode.
- Converts a single-command valid/ready request into a Z80-timed memory, IO or M1 cycle on addr, data, merq_n, iorq_n, sltsl_n, rd_n, wr_n and m1_n, then returns the read data.
- Used by the loader and by self-test to exercise cartridge mappers from FPGA logic.

Parameters:
- MEM_WAIT, 0, extra TW states inserted in non-M1 memory cycles.
- M1_WAIT, 1, extra TW states inserted in M1 cycles (MSX standard).
- IO_WAIT, 1, automatic TW states in IO cycles (Z80 standard).
- TIMEOUT, 255, TW tick limit; used only with MSX_BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tick  in  1  one-clk pulse per Z80 T-state (3.58 MHz equivalent)
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_type  in  2  00 mem rd, 01 mem wr, 10 io rd, 11 io wr
- cmd_m1  in  1  marks a mem rd as an opcode fetch; ignored for other types
- cmd_slot  in  1  assert sltsl_n during the memory cycle
- cmd_addr  in  16  bus address
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-clk pulse at cycle end
- rsp_rdata  out  8  captured read data (00 for writes)
- rsp_err  out  1  timeout flag, valid with rsp_valid
- addr  out  16  bus address
- cdout  out  8  data to bus
- cdout_oe  out  1  data driver enable
- cdin  in  8  data from bus
- wait_n  in  1  bus wait request, active low
- merq_n, iorq_n, sltsl_n, rd_n, wr_n, m1_n  out  1 each  bus strobes, active low

Behaviour:
- Reset:
  - All strobes 1, addr=0000, cdout=00, cdout_oe=0.
  - cmd_ready=1, rsp_valid=0, rsp_rdata=00, rsp_err=0.
  - FSM enters IDLE. Reset mid-cycle deasserts all strobes immediately, because reset is asynchronous.
- FSM states: IDLE, T1, T2, TW, T3, DONE. State advances only on clocks where tick=1, except DONE, which lasts exactly one clk.
- IDLE:
  - cmd_ready=1.
  - A handshake (cmd_valid & cmd_ready) latches all cmd_* fields, drops cmd_ready, and goes to T1. T1 is entered at the handshake clk, independent of tick.
- T1:
  - addr is driven from the latched address.
  - m1_n=0 if M1.
  - For mem rd: merq_n=0, rd_n=0, and sltsl_n=0 if cmd_slot.
  - For mem wr: merq_n=0, sltsl_n as for mem rd, cdout driven, cdout_oe=1.
- T2:
  - mem wr: wr_n=0.
  - io rd: iorq_n=0, rd_n=0.
  - io wr: iorq_n=0, wr_n=0, cdout_oe=1.
  - Wait count is loaded with M1_WAIT, MEM_WAIT or IO_WAIT according to the cycle type.
- TW:
  - Entered when the wait count is nonzero or wait_n=0 at the T2/TW tick.
  - The count decrements per tick. TW exits when count=0 and wait_n=1 are sampled on the same tick.
- T3:
  - Read data is sampled from cdin at the T3 tick into rsp_rdata.
  - All strobes rise and cdout_oe falls on that same tick.
  - m1_n also rises at T3; no refresh cycle is generated.
- DONE: rsp_valid=1 for one clk, cmd_ready returns to 1 the next clk. Back-to-back commands have at least one idle clk between cycles.
- Cycle length in ticks (T1 to T3 inclusive):
  - mem: 3 + MEM_WAIT.
  - M1: 3 + M1_WAIT.
  - io: 3 + IO_WAIT.
  - plus any wait_n-extended ticks.
- Write-cycle rsp_rdata is 00.
- Strobe overlap: merq_n and iorq_n are never low together; rd_n and wr_n are never low together.
- cmd_* changes while busy are ignored.

Optional Feature:
- MSX_BUS_TIMEOUT_EN:
  - With it defined, a TW tick counter (8 bits) that reaches TIMEOUT forces T3, sets rsp_rdata=FF and raises rsp_err=1 with rsp_valid.
  - Without it, wait_n=0 holds TW indefinitely and rsp_err is tied 0.

Decomposition:
- Shared package msx_bus_pkg:
  - cmd_type encodings: CMD_MEM_RD, CMD_MEM_WR, CMD_IO_RD, CMD_IO_WR.
  - FSM state enum.
  - Default wait constants.
- One natural sub-module, msx_wait_counter: wait/timeout counter with load, tick decrement, expired flag and timeout flag.

Test Plan:
- Mem rd, addr 4000, cmd_slot=1, cdin=A5, MEM_WAIT=0 -> merq_n/rd_n/sltsl_n low for 3 ticks, rsp_rdata=A5, one rsp_valid, wr_n stays 1.
- M1 fetch at 8000, cdin=3E -> m1_n low across 4 ticks (M1_WAIT=1), rsp_rdata=3E.
- IO wr port 8E, data 00 -> iorq_n/wr_n low from T2 for 3 ticks, merq_n stays 1, cdout=00 while cdout_oe=1.
- Mem wr 9000, data 3F, wait_n held low 5 ticks -> TW extends the cycle to 3+5 ticks, wr_n low throughout, rsp_rdata=00.
- Reset asserted during TW of an io rd -> all strobes 1 immediately; after release cmd_ready=1 and no rsp_valid.
- With MSX_BUS_TIMEOUT_EN and wait_n stuck low, mem rd -> after 255 TW ticks rsp_err=1, rsp_rdata=FF, strobes released.
